pipe_fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core; sits directly upstream of the hazard detection unit and decode.
- Owns the PC and arbitrates the single unified memory port between instruction fetch and the MEM-stage load/store, as selected by FetchMemSel.
- Consumes PCWrite, IF_ID_Write and FetchMemSel from hazard detection, plus branch/jump redirects resolved in ID.
- Produces IF_ID_Instruction, which is the hazard unit's input, and IF_ID_PC.

---
 rtl/pipe_fetch_stage.sv | 154 +++++++++++++++
 tb/tb_pipe_fetch_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch_stage.sv
// Instruction-fetch stage and IF/ID register; shares one memory port with MEM-stage loads/stores.
// Optional Perf_Fetched/Perf_Bubbles counters are built when PIPE_FETCH_PERF_CNT_EN is defined.
module pipe_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        FetchMemSel,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic [31:0] EX_MEM_Address,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic [3:0]  EX_MEM_ByteEnable,
  input  logic        EX_MEM_MemReadEn,
  input  logic        EX_MEM_MemWriteEn,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC,
  output logic        Fetch_Stall,
  output logic        active,
  output logic [31:0] PC
`ifdef PIPE_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] Perf_Fetched,
  output logic [31:0] Perf_Bubbles
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t      state;
  logic [1:0]  drain_cnt;
  logic        pend_vld;
  logic [31:0] pend_tgt;
  logic        run;
  logic        fetch_done;
  logic        advance;
  logic [31:0] pc_next;

  assign run = (state == RUN);

  // Reset drops any outstanding request at once rather than waiting for the next edge.
  always_comb begin
    address    = EX_MEM_Address;
    read       = EX_MEM_MemReadEn;
    write      = EX_MEM_MemWriteEn;
    byteenable = EX_MEM_ByteEnable;
    writedata  = EX_MEM_WriteData;
    if (FetchMemSel) begin
      address    = PC;
      read       = run;
      write      = 1'b0;
      byteenable = 4'hF;
    end
    if (reset) begin
      read  = 1'b0;
      write = 1'b0;
    end
  end

  assign fetch_done  = FetchMemSel & run & ~waitrequest;
  assign Fetch_Stall = FetchMemSel & read & waitrequest;
  assign advance     = PCWrite & fetch_done;
  assign pc_next     = pend_vld     ? pend_tgt :
                       Branch_Taken ? Branch_Target : PC + 32'd4;

  // ---- IF/ID pipeline register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IF_ID_Instruction <= '0;
      IF_ID_PC          <= '0;
    end else if (IF_ID_Write) begin
      if (fetch_done) begin
        IF_ID_Instruction <= readdata;
        IF_ID_PC          <= PC;
      end else begin
        IF_ID_Instruction <= '0;
      end
    end
  end

  // A redirect that arrives while the PC is frozen is held until the next advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC       <= RESET_VECTOR;
      pend_vld <= 1'b0;
      pend_tgt <= '0;
    end else if (advance) begin
      PC       <= pc_next;
      pend_vld <= 1'b0;
    end else if (Branch_Taken) begin
      pend_vld <= 1'b1;
      pend_tgt <= Branch_Target;
    end
  end

  // Halt sequencing: let four IF/ID loads (delay slot plus bubbles) pass before stopping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= '0;
      active    <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (advance && (pc_next == HALT_ADDR)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (IF_ID_Write) begin
            if (drain_cnt == 2'd3) begin
              state  <= HALTED;
              active <= 1'b0;
            end else begin
              drain_cnt <= drain_cnt + 2'd1;
            end
          end
        end
        HALTED: active <= 1'b0;
        default: begin
          state  <= HALTED;
          active <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Perf_Fetched <= '0;
      Perf_Bubbles <= '0;
    end else if ((state != HALTED) && IF_ID_Write) begin
      if (fetch_done) begin
        if (Perf_Fetched != 32'hFFFFFFFF) Perf_Fetched <= Perf_Fetched + 32'd1;
      end else begin
        if (Perf_Bubbles != 32'hFFFFFFFF) Perf_Bubbles <= Perf_Bubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Self-checking bench for pipe_fetch_stage: behavioural model checked every cycle plus directed literals.
module tb_pipe_fetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, IF_ID_Write, FetchMemSel, Branch_Taken;
  logic [31:0] Branch_Target, EX_MEM_Address, EX_MEM_WriteData;
  logic [3:0]  EX_MEM_ByteEnable;
  logic        EX_MEM_MemReadEn, EX_MEM_MemWriteEn;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;
  logic [31:0] IF_ID_Instruction, IF_ID_PC, PC;
  logic        Fetch_Stall, active;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_tgt, m_ins, m_ipc, npc;
  bit          m_pend, m_halted, m_run, m_fetch;
  int          m_drain;

  always #5 clk = ~clk;

  pipe_fetch_stage dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .FetchMemSel(FetchMemSel), .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .EX_MEM_Address(EX_MEM_Address), .EX_MEM_WriteData(EX_MEM_WriteData),
    .EX_MEM_ByteEnable(EX_MEM_ByteEnable), .EX_MEM_MemReadEn(EX_MEM_MemReadEn),
    .EX_MEM_MemWriteEn(EX_MEM_MemWriteEn), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC(IF_ID_PC),
    .Fetch_Stall(Fetch_Stall), .active(active), .PC(PC)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare process: check against the model, then advance the model by one clock edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_pc", PC, 32'hBFC00000);
      chk("rst_ins", IF_ID_Instruction, 32'h0);
      chk("rst_ipc", IF_ID_PC, 32'h0);
      chk("rst_active", 32'(active), 32'd1);
      m_pc = 32'hBFC00000; m_tgt = '0; m_ins = '0; m_ipc = '0;
      m_pend = 0; m_halted = 0; m_drain = -1;
    end else begin
      m_run   = (m_drain < 0) && !m_halted;
      m_fetch = FetchMemSel && m_run && !waitrequest;
      chk("m_pc", PC, m_pc);
      chk("m_ins", IF_ID_Instruction, m_ins);
      chk("m_ipc", IF_ID_PC, m_ipc);
      chk("m_active", 32'(active), 32'(!m_halted));
      chk("m_read", 32'(read), 32'(FetchMemSel ? m_run : EX_MEM_MemReadEn));
      chk("m_write", 32'(write), 32'(FetchMemSel ? 1'b0 : EX_MEM_MemWriteEn));
      chk("m_stall", 32'(Fetch_Stall), 32'(FetchMemSel && m_run && waitrequest));
      if (!FetchMemSel) begin
        chk("m_addr_mem", address, EX_MEM_Address);
        chk("m_wdata", writedata, EX_MEM_WriteData);
        chk("m_be_mem", 32'(byteenable), 32'(EX_MEM_ByteEnable));
      end else if (m_run) begin
        chk("m_addr_fetch", address, m_pc);
        chk("m_be_fetch", 32'(byteenable), 32'hF);
      end
      if (IF_ID_Write) begin
        if (m_fetch) begin
          m_ins = readdata;
          m_ipc = m_pc;
        end else begin
          m_ins = '0;
        end
      end
      if (m_drain >= 0 && IF_ID_Write) begin
        m_drain++;
        if (m_drain == 4) begin
          m_drain  = -1;
          m_halted = 1;
        end
      end
      if (PCWrite && m_fetch) begin
        npc    = m_pend ? m_tgt : (Branch_Taken ? Branch_Target : m_pc + 32'd4);
        m_pend = 0;
        m_pc   = npc;
        if (npc == 32'h0) m_drain = 0;
      end else if (Branch_Taken) begin
        m_pend = 1;
        m_tgt  = Branch_Target;
      end
    end
  end

  task automatic defaults();
    PCWrite = 1; IF_ID_Write = 1; FetchMemSel = 1; Branch_Taken = 0; Branch_Target = '0;
    EX_MEM_Address = '0; EX_MEM_WriteData = '0; EX_MEM_ByteEnable = '0;
    EX_MEM_MemReadEn = 0; EX_MEM_MemWriteEn = 0; readdata = '0; waitrequest = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1;
    defaults();
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // 1: first fetch out of reset
    readdata = 32'h24020005;
    #1;
    chk("t1_addr", address, 32'hBFC00000);
    chk("t1_read", 32'(read), 32'd1);
    step();
    chk("t1_ins", IF_ID_Instruction, 32'h24020005);
    chk("t1_ipc", IF_ID_PC, 32'hBFC00000);
    chk("t1_pc", PC, 32'hBFC00004);
    readdata = 32'h00000020;
    step();

    // 2: three wait states at BFC00008
    waitrequest = 1; readdata = 32'h8C430000;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t2_stall", 32'(Fetch_Stall), 32'd1);
      step();
      chk("t2_bubble", IF_ID_Instruction, 32'h0);
      chk("t2_pc_hold", PC, 32'hBFC00008);
    end
    waitrequest = 0; readdata = 32'h8C430004;
    step();
    chk("t2_ins", IF_ID_Instruction, 32'h8C430004);
    chk("t2_ipc", IF_ID_PC, 32'hBFC00008);
    chk("t2_pc", PC, 32'hBFC0000C);

    // 3: MEM-stage store takes the port
    FetchMemSel = 0; EX_MEM_MemWriteEn = 1; EX_MEM_Address = 32'h00001000;
    EX_MEM_WriteData = 32'hDEADBEEF; EX_MEM_ByteEnable = 4'hF;
    #1;
    chk("t3_write", 32'(write), 32'd1);
    chk("t3_read", 32'(read), 32'd0);
    chk("t3_addr", address, 32'h00001000);
    chk("t3_wdata", writedata, 32'hDEADBEEF);
    step();
    chk("t3_bubble", IF_ID_Instruction, 32'h0);
    chk("t3_pc", PC, 32'hBFC0000C);
    defaults();

    // 4: redirect while PC frozen becomes pending
    PCWrite = 0; Branch_Taken = 1; Branch_Target = 32'hBFC00100; readdata = 32'h11111111;
    step();
    chk("t4_pc_hold", PC, 32'hBFC0000C);
    PCWrite = 1; Branch_Taken = 0; Branch_Target = '0; readdata = 32'h22222222;
    step();
    chk("t4_pc_tgt", PC, 32'hBFC00100);
    chk("t4_ipc", IF_ID_PC, 32'hBFC0000C);
    step();
    chk("t4_pc_next", PC, 32'hBFC00104);

    // Randomized traffic, targets kept away from the halt address and the wrap point
    for (int i = 0; i < 400; i++) begin
      PCWrite           = ($urandom_range(0, 7) != 0);
      IF_ID_Write       = ($urandom_range(0, 7) != 0);
      FetchMemSel       = ($urandom_range(0, 3) != 0);
      waitrequest       = ($urandom_range(0, 3) == 0);
      Branch_Taken      = ($urandom_range(0, 7) == 0);
      Branch_Target     = 32'h00400000 + 32'($urandom_range(0, 4095) << 2) + 32'($urandom_range(0, 3));
      EX_MEM_Address    = $urandom;
      EX_MEM_WriteData  = $urandom;
      EX_MEM_ByteEnable = 4'($urandom);
      EX_MEM_MemReadEn  = 1'($urandom);
      EX_MEM_MemWriteEn = 1'($urandom);
      readdata          = $urandom;
      step();
    end

    // 5: jump to the halt address, drain, halt
    defaults();
    step();
    step();
    Branch_Taken = 1; Branch_Target = 32'h0; readdata = 32'h33333333;
    step();
    Branch_Taken = 0; readdata = 32'h44444444;
    #1;
    chk("t5_pc", PC, 32'h0);
    chk("t5_read", 32'(read), 32'd0);
    chk("t5_slot", IF_ID_Instruction, 32'h33333333);
    step();
    chk("t5_bubble", IF_ID_Instruction, 32'h0);
    IF_ID_Write = 0;
    step();
    IF_ID_Write = 1;
    step();
    step();
    chk("t5_active3", 32'(active), 32'd1);
    step();
    chk("t5_halted", 32'(active), 32'd0);
    repeat (5) step();
    chk("t5_stay", 32'(active), 32'd0);
    chk("t5_noread", 32'(read), 32'd0);

    // 6: reset out of HALTED
    reset = 1;
    #1;
    chk("t6_active", 32'(active), 32'd1);
    chk("t6_pc", PC, 32'hBFC00000);
    chk("t6_drop", 32'(read), 32'd0);
    step();
    reset = 0; readdata = 32'h55555555;
    #1;
    chk("t6_read", 32'(read), 32'd1);
    chk("t6_addr", address, 32'hBFC00000);
    step();
    chk("t6_pc4", PC, 32'hBFC00004);
    chk("t6_ins", IF_ID_Instruction, 32'h55555555);

    // PC + 4 wrap from FFFFFFFC lands on the halt address
    Branch_Taken = 1; Branch_Target = 32'hFFFFFFFC;
    step();
    Branch_Taken = 0;
    chk("wr_pc", PC, 32'hFFFFFFFC);
    step();
    chk("wr_zero", PC, 32'h0);
    repeat (4) step();
    chk("wr_halted", 32'(active), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
